mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  stage clock, rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 mem_aluop_i  in  8  op code (LB 0x90, LW 0x92, SB 0x98, SW 0x9A; others non-memory).
REQ-005 mem_wa_i / mem_wreg_i / mem_mreg_i  in  5/1/1  write address, register write enable, load-result select.
REQ-006 mem_wd_i  in  32  ALU result; the effective address for memory ops.
REQ-007 mem_din_i  in  32  store data.
REQ-008 mem_whilo_i / mem_hilo_i  in  1/64  HI/LO write enable and data.
REQ-009 mem_cp0_we_i / mem_cp0_waddr_i / mem_cp0_wdata_i  in  1/5/32  CP0 write request.
REQ-010 mem_pc_i / mem_in_delay_i / mem_exccode_i  in  32/1/5  PC, delay-slot flag, incoming exception code (0x10 = none).
REQ-011 flush_i  in  1  discard the current instruction.
REQ-012 dbus_req / dbus_we / dbus_addr / dbus_wdata  out  1/4/32/32  data-bus request, byte enables, word address, write data.
REQ-013 dbus_ack / dbus_rdata  in  1/32  transfer complete, read data.
REQ-014 mem_wa_o / mem_wreg_o / mem_dreg_o  out  5/1/32  write-back address, enable, data.
REQ-015 mem_whilo_o / mem_hilo_o, mem_cp0_we_o / mem_cp0_waddr_o / mem_cp0_wdata_o  out  pass-through; also the mem2exe forwarding sources.
REQ-016 mem_pc_o / mem_in_delay_o / mem_exccode_o / mem_badvaddr_o  out  32/1/5/32  exception information.
REQ-017 stallreq_mem  out  1  holds all upstream stages.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT, DONE, DRAIN.
REQ-019 IDLE, valid memory op, no exception, no flush: dbus_req=1 combinationally, stallreq_mem=1, next state WAIT.
REQ-020 WAIT: dbus_req=1 and stallreq_mem=1; addr/we/wdata stable; on dbus_ack capture dbus_rdata and go to DONE.
REQ-021 DONE: dbus_req=0, stallreq_mem=0, outputs commit; next state IDLE.
REQ-022 Minimum memory-op occupancy SHALL be 3 cycles (IDLE, WAIT+ack, DONE); each ack-less WAIT cycle adds one.
REQ-023 dbus_ack SHALL be ignored in IDLE and DONE.
REQ-024 Byte lanes SHALL be big-endian: addr[1:0]=0 selects bits 31:24; dbus_addr = {addr[31:2],2'b00}.
REQ-025 LB SHALL sign-extend the selected byte; SB SHALL drive a one-hot dbus_we lane and replicate din[7:0] into all four bytes.
REQ-026 LW/SW SHALL use dbus_we=0000/1111; loads SHALL always use dbus_we=0000.
REQ-027 LW with addr[1:0]!=0 SHALL set exccode 0x04; SW with addr[1:0]!=0 SHALL set exccode 0x05; badvaddr=addr; no bus request; no stall.
REQ-028 An incoming exccode != 0x10 SHALL suppress the bus request; the incoming code passes through unchanged.
REQ-029 Any excepting instruction SHALL force wreg, whilo and cp0_we outputs to 0.
REQ-030 mem_dreg_o SHALL be the aligned load data when mreg_i=1 in DONE, else mem_wd_i.
REQ-031 Non-memory ops SHALL pass through in one cycle with no stall.
REQ-032 flush_i in IDLE or DONE SHALL produce bubble outputs (all enables 0, exccode 0x10) and return to IDLE.
REQ-033 flush_i in WAIT SHALL move the FSM to DRAIN; DRAIN keeps dbus_req=1 until ack, discards the data, drops stallreq_mem, outputs a bubble, then returns to IDLE.

Reset
REQ-034 Reset SHALL put the FSM in IDLE, clear the load-data register and drive dbus_req=0.
REQ-035 Under reset, all enables SHALL be 0, data/addresses 0, exccode 0x10 and stallreq_mem 0.
REQ-036 Reset mid-WAIT SHALL abandon the transfer immediately; the memory model tolerates this.

Structure
REQ-037 Aluop codes, exccodes and the FSM state encoding SHALL live in shared package mips_defs.
REQ-038 Lane selection, extension and byte-enable generation SHALL live in combinational sub-module mem_align.

Verification
REQ-039 LW to 0x100, ack in the first WAIT cycle, rdata=0x12345678 -> 3 cycles, stall asserted in the first 2, dreg=0x12345678.
REQ-040 LB to 0x103, rdata=0x000000F0 -> dreg=0xFFFFFFF0; SB to 0x101, din=0xAB -> we=0100, wdata=0xABABABAB.
REQ-041 SW to 0x102 -> exccode 0x05, badvaddr=0x102, dbus_req never asserted, wreg=0.
REQ-042 LW with ack delayed 5 cycles, flush_i pulsed in the 2nd WAIT cycle -> req held until ack, bubble output, then IDLE.
REQ-043 rst asserted in WAIT -> dbus_req=0 the same cycle; the next LW completes normally.
REQ-044 MULT pass-through with whilo=1 and hilo=0x1_00000002 -> one-cycle output, no stall, forwarding outputs match.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS definitions: memory aluop codes, exception codes and the
// memory-stage FSM state encoding.
package mips_defs;

  localparam logic [7:0] ALUOP_LB = 8'h90;
  localparam logic [7:0] ALUOP_LW = 8'h92;
  localparam logic [7:0] ALUOP_SB = 8'h98;
  localparam logic [7:0] ALUOP_SW = 8'h9A;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_NONE = 5'h10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Big-endian byte-lane logic: op decode, store byte enables/data,
// load lane selection with sign extension, and alignment checking.
module mem_align
  import mips_defs::*;
(
  input  logic [7:0]  i_aluop,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_din,
  input  logic [31:0] i_rdata,
  output logic        o_is_mem,
  output logic        o_is_store,
  output logic        o_misalign,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0] w_byte;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_rdata[31:24];
      2'd1:    w_byte = i_rdata[23:16];
      2'd2:    w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  always_comb begin
    o_is_mem   = 1'b0;
    o_is_store = 1'b0;
    o_misalign = 1'b0;
    o_we       = '0;
    o_wdata    = '0;
    o_ldata    = '0;
    case (i_aluop)
      ALUOP_LB: begin
        o_is_mem = 1'b1;
        o_ldata  = {{24{w_byte[7]}}, w_byte};
      end
      ALUOP_LW: begin
        o_is_mem   = 1'b1;
        o_misalign = (i_off != 2'd0);
        o_ldata    = i_rdata;
      end
      ALUOP_SB: begin
        o_is_mem   = 1'b1;
        o_is_store = 1'b1;
        o_we       = 4'b1000 >> i_off;
        o_wdata    = {4{i_din[7:0]}};
      end
      ALUOP_SW: begin
        o_is_mem   = 1'b1;
        o_is_store = 1'b1;
        o_misalign = (i_off != 2'd0);
        o_we       = 4'b1111;
        o_wdata    = i_din;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: data-bus handshake FSM, address exceptions,
// flush/drain handling and write-back/forwarding outputs.
module mem_stage
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_aluop_i,
  input  logic [4:0]  mem_wa_i,
  input  logic        mem_wreg_i,
  input  logic        mem_mreg_i,
  input  logic [31:0] mem_wd_i,
  input  logic [31:0] mem_din_i,
  input  logic        mem_whilo_i,
  input  logic [63:0] mem_hilo_i,
  input  logic        mem_cp0_we_i,
  input  logic [4:0]  mem_cp0_waddr_i,
  input  logic [31:0] mem_cp0_wdata_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delay_i,
  input  logic [4:0]  mem_exccode_i,
  input  logic        flush_i,
  output logic        dbus_req,
  output logic [3:0]  dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [4:0]  mem_wa_o,
  output logic        mem_wreg_o,
  output logic [31:0] mem_dreg_o,
  output logic        mem_whilo_o,
  output logic [63:0] mem_hilo_o,
  output logic        mem_cp0_we_o,
  output logic [4:0]  mem_cp0_waddr_o,
  output logic [31:0] mem_cp0_wdata_o,
  output logic [31:0] mem_pc_o,
  output logic        mem_in_delay_o,
  output logic [4:0]  mem_exccode_o,
  output logic [31:0] mem_badvaddr_o,
  output logic        stallreq_mem
);

  mem_state_e  r_state, w_next;
  logic [31:0] r_ldata, r_addr, r_wdata;
  logic [3:0]  r_we;

  logic        w_is_mem, w_is_store, w_misalign;
  logic [3:0]  w_we;
  logic [31:0] w_wdata, w_ldata;
  logic        w_launch, w_hold, w_commit, w_use_ldata, w_exc;

  mem_align u_align (
    .i_aluop    (mem_aluop_i),
    .i_off      (mem_wd_i[1:0]),
    .i_din      (mem_din_i),
    .i_rdata    (dbus_rdata),
    .o_is_mem   (w_is_mem),
    .o_is_store (w_is_store),
    .o_misalign (w_misalign),
    .o_we       (w_we),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata)
  );

  // Bus request is latched at launch so DRAIN can keep it stable after the
  // upstream register has been flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ldata <= '0;
      r_addr  <= '0;
      r_we    <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_addr  <= {mem_wd_i[31:2], 2'b00};
        r_we    <= w_we;
        r_wdata <= w_wdata;
      end
      if (r_state == S_WAIT && dbus_ack)
        r_ldata <= w_ldata;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_launch        = 1'b0;
    w_hold          = 1'b0;
    w_commit        = 1'b0;
    w_use_ldata     = 1'b0;
    w_exc           = 1'b0;
    stallreq_mem    = 1'b0;
    dbus_req        = 1'b0;
    dbus_we         = '0;
    dbus_addr       = '0;
    dbus_wdata      = '0;
    mem_wa_o        = '0;
    mem_wreg_o      = 1'b0;
    mem_dreg_o      = '0;
    mem_whilo_o     = 1'b0;
    mem_hilo_o      = '0;
    mem_cp0_we_o    = 1'b0;
    mem_cp0_waddr_o = '0;
    mem_cp0_wdata_o = '0;
    mem_pc_o        = '0;
    mem_in_delay_o  = 1'b0;
    mem_exccode_o   = EXC_NONE;
    mem_badvaddr_o  = '0;

    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (!flush_i) begin
            if (mem_exccode_i != EXC_NONE) begin
              w_exc         = 1'b1;
              mem_exccode_o = mem_exccode_i;
            end else if (w_misalign) begin
              w_exc          = 1'b1;
              mem_exccode_o  = w_is_store ? EXC_ADES : EXC_ADEL;
              mem_badvaddr_o = mem_wd_i;
            end else if (w_is_mem) begin
              w_launch     = 1'b1;
              stallreq_mem = 1'b1;
              w_next       = S_WAIT;
            end else begin
              w_commit = 1'b1;
            end
          end
        end
        S_WAIT: begin
          w_hold       = 1'b1;
          stallreq_mem = 1'b1;
          // A flush coinciding with ack has nothing left to drain.
          if (flush_i)       w_next = dbus_ack ? S_IDLE : S_DRAIN;
          else if (dbus_ack) w_next = S_DONE;
        end
        S_DONE: begin
          w_next = S_IDLE;
          if (!flush_i) begin
            w_commit    = 1'b1;
            w_use_ldata = mem_mreg_i;
          end
        end
        S_DRAIN: begin
          w_hold = 1'b1;
          if (dbus_ack) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end

    if (w_launch) begin
      dbus_req   = 1'b1;
      dbus_we    = w_we;
      dbus_addr  = {mem_wd_i[31:2], 2'b00};
      dbus_wdata = w_wdata;
    end else if (w_hold) begin
      dbus_req   = 1'b1;
      dbus_we    = r_we;
      dbus_addr  = r_addr;
      dbus_wdata = r_wdata;
    end

    if (w_commit) begin
      mem_wa_o        = mem_wa_i;
      mem_wreg_o      = mem_wreg_i;
      mem_dreg_o      = w_use_ldata ? r_ldata : mem_wd_i;
      mem_whilo_o     = mem_whilo_i;
      mem_hilo_o      = mem_hilo_i;
      mem_cp0_we_o    = mem_cp0_we_i;
      mem_cp0_waddr_o = mem_cp0_waddr_i;
      mem_cp0_wdata_o = mem_cp0_wdata_i;
    end
    if (w_commit || w_exc) begin
      mem_pc_o       = mem_pc_i;
      mem_in_delay_o = mem_in_delay_i;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table from IDLE plus
// hand-written multi-cycle bus sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [4:0]  wa_i;
  logic        wreg_i, mreg_i;
  logic [31:0] wd_i, din_i;
  logic        whilo_i;
  logic [63:0] hilo_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] cp0_wdata_i;
  logic [31:0] pc_i;
  logic        in_delay_i;
  logic [4:0]  exc_i;
  logic        flush;
  logic        req;
  logic [3:0]  we;
  logic [31:0] addr, wdata;
  logic        ack;
  logic [31:0] rdata;
  logic [4:0]  wa_o;
  logic        wreg_o;
  logic [31:0] dreg_o;
  logic        whilo_o;
  logic [63:0] hilo_o;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o;
  logic [31:0] pc_o;
  logic        in_delay_o;
  logic [4:0]  exc_o;
  logic [31:0] bad_o;
  logic        stall;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] HILO = 64'h1_0000_0002;
  localparam logic [31:0] CP0D = 32'h0000_C0C0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .mem_aluop_i(aluop), .mem_wa_i(wa_i), .mem_wreg_i(wreg_i), .mem_mreg_i(mreg_i),
    .mem_wd_i(wd_i), .mem_din_i(din_i), .mem_whilo_i(whilo_i), .mem_hilo_i(hilo_i),
    .mem_cp0_we_i(cp0_we_i), .mem_cp0_waddr_i(cp0_waddr_i), .mem_cp0_wdata_i(cp0_wdata_i),
    .mem_pc_i(pc_i), .mem_in_delay_i(in_delay_i), .mem_exccode_i(exc_i), .flush_i(flush),
    .dbus_req(req), .dbus_we(we), .dbus_addr(addr), .dbus_wdata(wdata),
    .dbus_ack(ack), .dbus_rdata(rdata),
    .mem_wa_o(wa_o), .mem_wreg_o(wreg_o), .mem_dreg_o(dreg_o),
    .mem_whilo_o(whilo_o), .mem_hilo_o(hilo_o),
    .mem_cp0_we_o(cp0_we_o), .mem_cp0_waddr_o(cp0_waddr_o), .mem_cp0_wdata_o(cp0_wdata_o),
    .mem_pc_o(pc_o), .mem_in_delay_o(in_delay_o), .mem_exccode_o(exc_o),
    .mem_badvaddr_o(bad_o), .stallreq_mem(stall)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] wd, input logic [31:0] din,
                        input logic wreg, input logic mreg);
    aluop  = op;
    wd_i   = wd;
    din_i  = din;
    wreg_i = wreg;
    mreg_i = mreg;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic        wreg;
    logic [31:0] wd;
    logic [31:0] din;
    logic        whilo;
    logic [4:0]  exc;
    logic        flush;
    logic [4:0]  e_en;   // {req, stall, wreg, whilo, cp0_we}
    logic [3:0]  e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_dreg;
    logic [4:0]  e_exc;
    logic [31:0] e_bad;
    logic [63:0] e_hilo;
    logic [31:0] e_cp0d;
  } vec_t;

  vec_t vt[12];

  initial begin
    // op      wreg wd            din            whilo exc    flush en        we       addr           wdata          dreg           exc    bad          hilo  cp0d
    vt[0]  = '{8'h18, 1'b0, 32'h55,        32'h0,         1'b1, 5'h10, 1'b0, 5'b00011, 4'b0000, 32'h0,         32'h0,         32'h55,        5'h10, 32'h0,       HILO, CP0D};
    vt[1]  = '{8'h20, 1'b1, 32'hDEADBEEF,  32'h0,         1'b0, 5'h10, 1'b0, 5'b00101, 4'b0000, 32'h0,         32'h0,         32'hDEADBEEF,  5'h10, 32'h0,       HILO, CP0D};
    vt[2]  = '{8'h9A, 1'b0, 32'h102,       32'h11223344,  1'b0, 5'h10, 1'b0, 5'b00000, 4'b0000, 32'h0,         32'h0,         32'h0,         5'h05, 32'h102,     64'h0, 32'h0};
    vt[3]  = '{8'h92, 1'b1, 32'h101,       32'h0,         1'b0, 5'h10, 1'b0, 5'b00000, 4'b0000, 32'h0,         32'h0,         32'h0,         5'h04, 32'h101,     64'h0, 32'h0};
    vt[4]  = '{8'h92, 1'b1, 32'h100,       32'h0,         1'b0, 5'h0C, 1'b0, 5'b00000, 4'b0000, 32'h0,         32'h0,         32'h0,         5'h0C, 32'h0,       64'h0, 32'h0};
    vt[5]  = '{8'h20, 1'b1, 32'h77,        32'h0,         1'b1, 5'h10, 1'b1, 5'b00000, 4'b0000, 32'h0,         32'h0,         32'h0,         5'h10, 32'h0,       64'h0, 32'h0};
    vt[6]  = '{8'h98, 1'b0, 32'h101,       32'h000000AB,  1'b0, 5'h10, 1'b0, 5'b11000, 4'b0100, 32'h100,       32'hABABABAB,  32'h0,         5'h10, 32'h0,       64'h0, 32'h0};
    vt[7]  = '{8'h9A, 1'b0, 32'h200,       32'hCAFEF00D,  1'b0, 5'h10, 1'b0, 5'b11000, 4'b1111, 32'h200,       32'hCAFEF00D,  32'h0,         5'h10, 32'h0,       64'h0, 32'h0};
    vt[8]  = '{8'h90, 1'b1, 32'h103,       32'h0,         1'b0, 5'h10, 1'b0, 5'b11000, 4'b0000, 32'h100,       32'h0,         32'h0,         5'h10, 32'h0,       64'h0, 32'h0};
    vt[9]  = '{8'h98, 1'b0, 32'h103,       32'h1234567E,  1'b0, 5'h10, 1'b0, 5'b11000, 4'b0001, 32'h100,       32'h7E7E7E7E,  32'h0,         5'h10, 32'h0,       64'h0, 32'h0};
    vt[10] = '{8'h92, 1'b1, 32'h102,       32'h0,         1'b0, 5'h10, 1'b1, 5'b00000, 4'b0000, 32'h0,         32'h0,         32'h0,         5'h10, 32'h0,       64'h0, 32'h0};
    vt[11] = '{8'h20, 1'b1, 32'h33,        32'h0,         1'b1, 5'h0A, 1'b0, 5'b00000, 4'b0000, 32'h0,         32'h0,         32'h0,         5'h0A, 32'h0,       64'h0, 32'h0};

    rst = 1'b1;
    set_op(8'h92, 32'h100, 32'h0, 1'b1, 1'b1);
    wa_i = 5'd3; whilo_i = 1'b1; hilo_i = HILO;
    cp0_we_i = 1'b1; cp0_waddr_i = 5'd12; cp0_wdata_i = CP0D;
    pc_i = 32'h400; in_delay_i = 1'b0; exc_i = 5'h10; flush = 1'b0;
    ack = 1'b0; rdata = '0;

    // Reset state with a valid LW on the inputs
    @(negedge clk); #2;
    chk("rst_req", req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_wreg", {wreg_o, whilo_o, cp0_we_o}, 3'b000);
    chk("rst_exc", exc_o, 5'h10);
    chk("rst_dreg", dreg_o, 32'h0);
    chk("rst_addr", addr, 32'h0);

    // Table: each row starts from IDLE after an asynchronous reset pulse
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rst = 1'b1; #1; rst = 1'b0;
      set_op(vt[i].op, vt[i].wd, vt[i].din, vt[i].wreg, 1'b0);
      whilo_i = vt[i].whilo; exc_i = vt[i].exc; flush = vt[i].flush;
      #1;
      chk($sformatf("row%0d_en", i), {req, stall, wreg_o, whilo_o, cp0_we_o}, vt[i].e_en);
      chk($sformatf("row%0d_we", i), we, vt[i].e_we);
      chk($sformatf("row%0d_addr", i), addr, vt[i].e_addr);
      chk($sformatf("row%0d_wdata", i), wdata, vt[i].e_wdata);
      chk($sformatf("row%0d_dreg", i), dreg_o, vt[i].e_dreg);
      chk($sformatf("row%0d_exc", i), exc_o, vt[i].e_exc);
      chk($sformatf("row%0d_bad", i), bad_o, vt[i].e_bad);
      chk($sformatf("row%0d_hilo", i), hilo_o, vt[i].e_hilo);
      chk($sformatf("row%0d_cp0d", i), cp0_wdata_o, vt[i].e_cp0d);
    end

    @(negedge clk);
    rst = 1'b1; #1; rst = 1'b0;
    exc_i = 5'h10; flush = 1'b0; whilo_i = 1'b0;

    // LW 0x100, ack in first WAIT cycle
    set_op(8'h92, 32'h100, 32'h0, 1'b1, 1'b1);
    #1;
    chk("lw_c1_req_stall", {req, stall}, 2'b11);
    @(negedge clk); ack = 1'b1; rdata = 32'h12345678; #2;
    chk("lw_c2_req_stall", {req, stall}, 2'b11);
    chk("lw_c2_addr", addr, 32'h100);
    chk("lw_c2_we", we, 4'b0000);
    @(negedge clk); rdata = 32'hDEADDEAD; #2;
    chk("lw_c3_req_stall", {req, stall}, 2'b00);
    chk("lw_c3_wreg", wreg_o, 1'b1);
    chk("lw_c3_dreg", dreg_o, 32'h12345678);
    @(negedge clk); set_op(8'h20, 32'h9, 32'h0, 1'b1, 1'b0); #2;
    chk("lw_c4_idle", {req, stall, wreg_o}, 3'b001);
    chk("lw_c4_dreg", dreg_o, 32'h9);
    @(negedge clk); ack = 1'b0; #2;
    chk("ack_idle_ignored", {req, stall}, 2'b00);

    // LB 0x103 with one ack-less WAIT cycle
    @(negedge clk); set_op(8'h90, 32'h103, 32'h0, 1'b1, 1'b1); #2;
    chk("lb_c1_req", req, 1'b1);
    @(negedge clk); #2;
    chk("lb_c2_wait", {req, stall}, 2'b11);
    chk("lb_c2_addr", addr, 32'h100);
    @(negedge clk); ack = 1'b1; rdata = 32'h000000F0; #2;
    chk("lb_c3_req", req, 1'b1);
    @(negedge clk); ack = 1'b0; rdata = '0; #2;
    chk("lb_c4_stall", stall, 1'b0);
    chk("lb_c4_dreg", dreg_o, 32'hFFFFFFF0);

    // LW with delayed ack, flush in 2nd WAIT cycle
    @(negedge clk); set_op(8'h92, 32'h100, 32'h0, 1'b1, 1'b1); #2;
    chk("fl_c1_req", req, 1'b1);
    @(negedge clk); #2;
    chk("fl_w1", {req, stall}, 2'b11);
    @(negedge clk); flush = 1'b1; #2;
    chk("fl_w2", {req, stall, wreg_o}, 3'b110);
    @(negedge clk); flush = 1'b0; set_op(8'h20, 32'h55, 32'h0, 1'b1, 1'b0); #2;
    chk("fl_d1", {req, stall, wreg_o}, 3'b100);
    chk("fl_d1_addr", addr, 32'h100);
    chk("fl_d1_exc", exc_o, 5'h10);
    @(negedge clk); #2;
    chk("fl_d2", {req, stall, wreg_o}, 3'b100);
    @(negedge clk); ack = 1'b1; rdata = 32'h0BADF00D; #2;
    chk("fl_d3", {req, stall, wreg_o}, 3'b100);
    @(negedge clk); ack = 1'b0; #2;
    chk("fl_idle", {req, stall, wreg_o}, 3'b001);
    chk("fl_idle_dreg", dreg_o, 32'h55);

    // Reset while in WAIT, then a normal LW
    @(negedge clk); set_op(8'h92, 32'h300, 32'h0, 1'b1, 1'b1); #2;
    chk("rw_c1_req", req, 1'b1);
    @(negedge clk); #2;
    chk("rw_wait", {req, stall}, 2'b11);
    #1; rst = 1'b1; #1;
    chk("rw_rst", {req, stall, wreg_o}, 3'b000);
    chk("rw_rst_exc", exc_o, 5'h10);
    @(negedge clk); rst = 1'b0; set_op(8'h92, 32'h100, 32'h0, 1'b1, 1'b1); #2;
    chk("rw_relaunch", {req, stall}, 2'b11);
    @(negedge clk); ack = 1'b1; rdata = 32'hA5A55A5A; #2;
    chk("rw_wait2", req, 1'b1);
    @(negedge clk); ack = 1'b0; #2;
    chk("rw_done", {req, stall, wreg_o}, 3'b001);
    chk("rw_done_dreg", dreg_o, 32'hA5A55A5A);

    @(negedge clk); set_op(8'h00, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
